pipeline_regfile_wb: RTL and testbench

// - Integer register file and write-back endpoint for the 5-stage pipeline.
// - Serves the IDC/IDR read ports (rs1/rs2 -> data_reg_read_1/2).
// - Accepts the WB-stage write port.
// - Keeps a per-register pending-write scoreboard so the hazard unit can stall or forward.
// - Read side: combinational. Writes, scoreboard counters and error flag: clocked state.

---
 rtl/pipeline_regfile_wb_if.sv | 33 +++
 rtl/pipeline_regfile_wb.sv | 99 +++++++++
 tb/tb_pipeline_regfile_wb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_regfile_wb_if.sv
// rtl/pipeline_regfile_wb_if.sv - read, write-back, issue/kill and hazard signals of the register file
interface pipeline_regfile_wb_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1_IDC;
  logic [AW-1:0]   rs2_IDC;
  logic [XLEN-1:0] data_reg_read_1;
  logic [XLEN-1:0] data_reg_read_2;
  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic            kill_en;
  logic [AW-1:0]   kill_rd;
  logic            busy_rs1;
  logic            busy_rs2;
  logic            issue_stall;
  logic            sb_err;

  modport master (
    output rs1_IDC, rs2_IDC, wb_en, wb_rd, wb_data,
           issue_en, issue_rd, kill_en, kill_rd,
    input  data_reg_read_1, data_reg_read_2, busy_rs1, busy_rs2, issue_stall, sb_err
  );

  modport slave (
    input  rs1_IDC, rs2_IDC, wb_en, wb_rd, wb_data,
           issue_en, issue_rd, kill_en, kill_rd,
    output data_reg_read_1, data_reg_read_2, busy_rs1, busy_rs2, issue_stall, sb_err
  );
endinterface

// File: rtl/pipeline_regfile_wb.sv
// rtl/pipeline_regfile_wb.sv - integer register file with write-back port and pending-write scoreboard (option: REGFILE_BYPASS_EN)
module pipeline_regfile_wb #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input logic                  clk,
  input logic                  reset,
  pipeline_regfile_wb_if.slave bus
);
  localparam int AW = 5;
  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  regs    [NREG];
  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic             stall;
  logic             err_nxt;
  logic             sb_err_q;
  logic             inc;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    dec;

  // A full counter blocks the issue; x0 has no counter so it never stalls
  always_comb begin
    stall = bus.issue_en && (bus.issue_rd != '0) && (cnt[bus.issue_rd] == CNT_MAX);
  end

  // Net out issue, retire and kill per register; clamp underflow at zero and flag it
  always_comb begin
    err_nxt    = 1'b0;
    inc        = 1'b0;
    sum        = '0;
    dec        = '0;
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc = bus.issue_en && (bus.issue_rd == AW'(r)) && !stall;
      sum = SW'(cnt[r]) + SW'(inc);
      dec = SW'(bus.wb_en && (bus.wb_rd == AW'(r))) + SW'(bus.kill_en && (bus.kill_rd == AW'(r)));
      if (dec > sum) begin
        cnt_nxt[r] = '0;
        err_nxt    = 1'b1;
      end else begin
        cnt_nxt[r] = CNT_W'(sum - dec);
      end
    end
  end

  // Combinational read ports and hazard status, x0 forced to zero
  always_comb begin
    bus.issue_stall = stall;
    bus.sb_err      = sb_err_q;
`ifdef REGFILE_BYPASS_EN
    if (bus.rs1_IDC == '0)
      bus.data_reg_read_1 = '0;
    else if (bus.wb_en && (bus.wb_rd == bus.rs1_IDC))
      bus.data_reg_read_1 = bus.wb_data;
    else
      bus.data_reg_read_1 = regs[bus.rs1_IDC];
    if (bus.rs2_IDC == '0)
      bus.data_reg_read_2 = '0;
    else if (bus.wb_en && (bus.wb_rd == bus.rs2_IDC))
      bus.data_reg_read_2 = bus.wb_data;
    else
      bus.data_reg_read_2 = regs[bus.rs2_IDC];
    // The retiring write is already forwarded, so it no longer counts as pending when it was the last one
    bus.busy_rs1 = (cnt[bus.rs1_IDC] != '0) &&
                   !(bus.wb_en && (bus.wb_rd != '0) && (bus.wb_rd == bus.rs1_IDC) && (cnt_nxt[bus.rs1_IDC] == '0));
    bus.busy_rs2 = (cnt[bus.rs2_IDC] != '0) &&
                   !(bus.wb_en && (bus.wb_rd != '0) && (bus.wb_rd == bus.rs2_IDC) && (cnt_nxt[bus.rs2_IDC] == '0));
`else
    bus.data_reg_read_1 = (bus.rs1_IDC == '0) ? '0 : regs[bus.rs1_IDC];
    bus.data_reg_read_2 = (bus.rs2_IDC == '0) ? '0 : regs[bus.rs2_IDC];
    bus.busy_rs1        = (cnt[bus.rs1_IDC] != '0);
    bus.busy_rs2        = (cnt[bus.rs2_IDC] != '0);
`endif
  end

  // Register storage; writes to x0 are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (bus.wb_en && (bus.wb_rd != '0)) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Scoreboard counters and sticky underflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
      if (err_nxt) sb_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_regfile_wb.sv
// tb/tb_pipeline_regfile_wb.sv - directed self-checking bench for pipeline_regfile_wb
module tb_pipeline_regfile_wb;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [63:0] V5  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] V31 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] V7  = 64'h7777_0000_1234_5678;

  pipeline_regfile_wb_if #(.XLEN(64)) bus ();

  pipeline_regfile_wb #(.XLEN(64), .NREG(32), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_en    = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.issue_en = 1'b0;
    bus.issue_rd = '0;
    bus.kill_en  = 1'b0;
    bus.kill_rd  = '0;
  endtask

  task automatic apply_reset();
    step();
    #2 reset = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle();
    bus.rs1_IDC = '0;
    bus.rs2_IDC = '0;
    step();
    step();
    reset = 1'b1;
    step();
    for (int r = 1; r < 32; r++) begin
      bus.rs1_IDC = 5'(r);
      bus.rs2_IDC = 5'(31 - r + 1);
      #1;
      checks++; if (bus.data_reg_read_1 !== 64'd0) begin errors++; $display("FAIL rst_rd1 x%0d got %h want 0", r, bus.data_reg_read_1); end
      checks++; if (bus.data_reg_read_2 !== 64'd0) begin errors++; $display("FAIL rst_rd2 x%0d got %h want 0", 32 - r, bus.data_reg_read_2); end
      checks++; if ({bus.busy_rs1, bus.busy_rs2} !== 2'b00) begin errors++; $display("FAIL rst_busy x%0d got %b want 00", r, {bus.busy_rs1, bus.busy_rs2}); end
    end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL rst_sb_err got %b want 0", bus.sb_err); end
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", bus.issue_stall); end
  endtask

  task automatic test_write_read();
    step();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = V5; bus.rs1_IDC = 5'd5; bus.rs2_IDC = 5'd6;
    #1;
    checks++; if (bus.data_reg_read_1 !== (BYP ? V5 : 64'd0)) begin errors++; $display("FAIL wr_same_cycle got %h want %h", bus.data_reg_read_1, BYP ? V5 : 64'd0); end
    checks++; if (bus.data_reg_read_2 !== 64'd0) begin errors++; $display("FAIL wr_other_reg got %h want 0", bus.data_reg_read_2); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL wr_err_before got %b want 0", bus.sb_err); end
    step();
    bus.wb_rd = 5'd31; bus.wb_data = V31; bus.rs2_IDC = 5'd31;
    #1;
    checks++; if (bus.data_reg_read_1 !== V5) begin errors++; $display("FAIL wr_next_cycle got %h want %h", bus.data_reg_read_1, V5); end
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL wr_underflow_err got %b want 1", bus.sb_err); end
    step();
    idle();
    #1;
    checks++; if (bus.data_reg_read_2 !== V31) begin errors++; $display("FAIL wr_x31 got %h want %h", bus.data_reg_read_2, V31); end
  endtask

  task automatic test_x0();
    step();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = '1; bus.rs2_IDC = 5'd0; bus.rs1_IDC = 5'd0;
    #1;
    checks++; if (bus.data_reg_read_2 !== 64'd0) begin errors++; $display("FAIL x0_same got %h want 0", bus.data_reg_read_2); end
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.data_reg_read_2 !== 64'd0) begin errors++; $display("FAIL x0_later%0d got %h want 0", i, bus.data_reg_read_2); end
      step();
    end
    checks++; if ({bus.busy_rs2, bus.sb_err} !== 2'b00) begin errors++; $display("FAIL x0_busy_err got %b want 00", {bus.busy_rs2, bus.sb_err}); end
  endtask

  task automatic test_overflow();
    step();
    bus.rs1_IDC = 5'd7;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL ovf_issue%0d_stall got %b want 0", i, bus.issue_stall); end
      checks++; if (bus.busy_rs1 !== (i != 0)) begin errors++; $display("FAIL ovf_issue%0d_busy got %b want %b", i, bus.busy_rs1, i != 0); end
      step();
    end
    #1;
    checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL ovf_4th_stall got %b want 1", bus.issue_stall); end
    step();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = V7;
    #1;
    checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL ovf_held_stall got %b want 1", bus.issue_stall); end
    checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL ovf_held_busy got %b want 1", bus.busy_rs1); end
    step();
    bus.wb_en = 1'b0;
    #1;
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL ovf_retry_stall got %b want 0", bus.issue_stall); end
    checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL ovf_retry_busy got %b want 1", bus.busy_rs1); end
    checks++; if (bus.data_reg_read_1 !== V7) begin errors++; $display("FAIL ovf_x7_data got %h want %h", bus.data_reg_read_1, V7); end
    step();
    #1;
    checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL ovf_full_again got %b want 1", bus.issue_stall); end
    bus.issue_en = 1'b0; bus.wb_en = 1'b1;
    step();
    bus.issue_en = 1'b1;
    #1;
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL net_stall got %b want 0", bus.issue_stall); end
    step();
    bus.wb_en = 1'b0;
    #1;
    checks++; if (bus.issue_stall !== 1'b0) begin errors++; $display("FAIL net_count2 got %b want 0", bus.issue_stall); end
    step();
    #1;
    checks++; if (bus.issue_stall !== 1'b1) begin errors++; $display("FAIL net_count3 got %b want 1", bus.issue_stall); end
    bus.issue_en = 1'b0; bus.wb_en = 1'b1;
    step();
    step();
    #1;
    checks++; if (bus.busy_rs1 !== !BYP) begin errors++; $display("FAIL drain_last_busy got %b want %b", bus.busy_rs1, !BYP); end
    step();
    bus.wb_en = 1'b0;
    #1;
    checks++; if ({bus.busy_rs1, bus.sb_err} !== 2'b00) begin errors++; $display("FAIL drain_done got %b want 00", {bus.busy_rs1, bus.sb_err}); end
  endtask

  task automatic test_underflow();
    step();
    bus.rs1_IDC = 5'd9;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd9;
    step();
    bus.issue_en = 1'b0;
    bus.kill_en = 1'b1; bus.kill_rd = 5'd9;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 64'h99;
    #1;
    checks++; if (bus.busy_rs1 !== !BYP) begin errors++; $display("FAIL unf_busy_pre got %b want %b", bus.busy_rs1, !BYP); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL unf_err_pre got %b want 0", bus.sb_err); end
    step();
    idle();
    #1;
    checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL unf_busy got %b want 0", bus.busy_rs1); end
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL unf_err got %b want 1", bus.sb_err); end
    step();
    step();
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL unf_sticky got %b want 1", bus.sb_err); end
  endtask

  task automatic test_async_reset();
    step();
    bus.wb_en = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = V7;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd3; bus.rs1_IDC = 5'd3; bus.rs2_IDC = 5'd7;
    step();
    bus.wb_en = 1'b0;
    step();
    bus.issue_en = 1'b0;
    #1;
    checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL ar_busy_pre got %b want 1", bus.busy_rs1); end
    checks++; if (bus.data_reg_read_2 !== V7) begin errors++; $display("FAIL ar_data_pre got %h want %h", bus.data_reg_read_2, V7); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL ar_busy_now got %b want 0", bus.busy_rs1); end
    checks++; if (bus.data_reg_read_2 !== 64'd0) begin errors++; $display("FAIL ar_data_now got %h want 0", bus.data_reg_read_2); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL ar_err_now got %b want 0", bus.sb_err); end
    step();
    reset = 1'b1;
    step();
    #1;
    checks++; if (bus.busy_rs1 !== 1'b0) begin errors++; $display("FAIL ar_busy_after got %b want 0", bus.busy_rs1); end
    bus.issue_en = 1'b1; bus.issue_rd = 5'd3;
    step();
    bus.issue_en = 1'b0;
    #1;
    checks++; if (bus.busy_rs1 !== 1'b1) begin errors++; $display("FAIL ar_first_issue got %b want 1", bus.busy_rs1); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    apply_reset();
    test_x0();
    test_overflow();
    test_underflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
